// File: rtl/requant_pkg.sv
// Shared definitions for the requant fixed-point narrowing stage.
package requant_pkg;
   typedef enum logic [1:0] {
      RND_TRUNC     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2
   } rnd_mode_e;

   localparam int OVF_CNT_W = 16;
endpackage

// File: rtl/requant_if.sv
// Sample-in / sample-out handshake bundle of the requant block.
interface requant_if #(
   parameter int N_BITS_IN  = 8,
   parameter int N_BITS_OUT = 4
) ();
   import requant_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [N_BITS_IN-1:0]  din;
   logic [1:0]            rnd_mode;
   logic                  sat_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_BITS_OUT-1:0] dout;
   logic                  ovf;
   logic [OVF_CNT_W-1:0]  ovf_cnt;
   logic                  cnt_clr;

   modport slave (
      input  in_valid, din, rnd_mode, sat_en, out_ready, cnt_clr,
      output in_ready, out_valid, dout, ovf, ovf_cnt
   );

   modport master (
      output in_valid, din, rnd_mode, sat_en, out_ready, cnt_clr,
      input  in_ready, out_valid, dout, ovf, ovf_cnt
   );
endinterface

// File: rtl/requant_pipe_stage.sv
// One valid/ready register slice; full throughput, ready looks through to downstream.
module pipe_stage #(
   parameter int WIDTH      = 8,
   parameter bit RESET_DATA = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      in_ready = !valid_q || out_ready;
      valid_d  = in_ready ? in_valid : valid_q;
      data_d   = (in_valid && in_ready) ? in_data : data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= valid_d;
   end

   generate
      if (RESET_DATA) begin : g_rst_data
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) data_q <= '0;
            else        data_q <= data_d;
         end
      end else begin : g_no_rst_data
         always_ff @(posedge clk) data_q <= data_d;
      end
   endgenerate

   assign out_valid = valid_q;
   assign out_data  = data_q;
endmodule

// File: rtl/requant.sv
// Two-stage fixed-point narrowing: S1 drops fractional LSBs with rounding,
// S2 range-checks into the output word with saturate or wrap.
module requant
   import requant_pkg::*;
#(
   parameter int N_BITS_IN  = 8,
   parameter int BIN_PT_IN  = 7,
   parameter int N_BITS_OUT = 4,
   parameter int BIN_PT_OUT = 3
) (
   input logic      clk,
   input logic      rst_n,
   requant_if.slave bus
);
   localparam int D    = BIN_PT_IN - BIN_PT_OUT;
   localparam int RW   = N_BITS_IN - D + 1;
   localparam int S1_W = RW + 1;
   localparam int S2_W = N_BITS_OUT + 1;

   generate
      if (!(BIN_PT_OUT < BIN_PT_IN && (N_BITS_OUT - BIN_PT_OUT) <= (N_BITS_IN - BIN_PT_IN)))
      begin : g_bad_params
         $error("requant: only narrowing requantisation is supported");
      end
   endgenerate

   localparam logic signed [N_BITS_IN:0] HALF    = (N_BITS_IN+1)'(2 ** (D-1));
   localparam logic signed [N_BITS_IN:0] HALF_M1 = (N_BITS_IN+1)'(2 ** (D-1) - 1);
   localparam logic signed [RW-1:0]      MAXV    = RW'(2 ** (N_BITS_OUT-1) - 1);
   localparam logic signed [RW-1:0]      MINV    = ~MAXV;

   // One guard bit above the input keeps the rounding add from wrapping.
   function automatic logic signed [RW-1:0] round_f(input logic signed [N_BITS_IN-1:0] x,
                                                     input logic [1:0] mode);
      logic signed [N_BITS_IN:0] ext, sum, shr;
      ext = {x[N_BITS_IN-1], x};
      case (mode)
         RND_HALF_UP:   sum = ext + HALF;
         RND_HALF_EVEN: sum = ext + HALF_M1 + {{N_BITS_IN{1'b0}}, x[D]};
         default:       sum = ext;
      endcase
      shr = sum >>> D;
      return shr[RW-1:0];
   endfunction

   // Returns {ovf, dout}.
   function automatic logic [N_BITS_OUT:0] range_f(input logic signed [RW-1:0] r,
                                                    input logic sat);
      logic hi, lo;
      logic [N_BITS_OUT-1:0] y;
      hi = r > MAXV;
      lo = r < MINV;
      y  = r[N_BITS_OUT-1:0];
      if (sat && hi)      y = MAXV[N_BITS_OUT-1:0];
      else if (sat && lo) y = MINV[N_BITS_OUT-1:0];
      return {hi || lo, y};
   endfunction

   logic [S1_W-1:0]       s1_in, s1_out;
   logic [S2_W-1:0]       s2_in, s2_out;
   logic signed [RW-1:0]  s1_val;
   logic                  s1_valid, s2_ready;

   always_comb begin
      s1_in  = {bus.sat_en, round_f(bus.din, bus.rnd_mode)};
      s1_val = s1_out[RW-1:0];
      s2_in  = range_f(s1_val, s1_out[RW]);
   end

   pipe_stage #(.WIDTH(S1_W), .RESET_DATA(1'b0)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_out)
   );

   pipe_stage #(.WIDTH(S2_W), .RESET_DATA(1'b1)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (s2_out)
   );

   assign bus.dout = s2_out[N_BITS_OUT-1:0];
   assign bus.ovf  = s2_out[N_BITS_OUT];

   logic [OVF_CNT_W-1:0] ovf_cnt_d, ovf_cnt_q;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (bus.cnt_clr)
         ovf_cnt_d = '0;
      else if (bus.out_valid && bus.out_ready && bus.ovf && (ovf_cnt_q != '1))
         ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign bus.ovf_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_requant.sv
// Directed and streamed stimulus for requant (8/7 -> 4/3) with a queue scoreboard.
module tb_requant;
   import requant_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;
   int   n0;
   logic stream_done = 1'b0;
   logic [4:0] exp_q[$];
   logic       stall_prev = 1'b0;
   logic [3:0] prev_dout;
   logic       prev_ovf;
   logic [4:0] exp5;

   requant_if #(.N_BITS_IN(8), .N_BITS_OUT(4)) bus ();

   requant #(.N_BITS_IN(8), .BIN_PT_IN(7), .N_BITS_OUT(4), .BIN_PT_OUT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: returns {ovf, dout} from integer arithmetic.
   function automatic logic [4:0] model(input logic [7:0] d, input logic [1:0] m, input logic s);
      int x, q, r;
      logic o;
      logic [3:0] y;
      x = $signed(d);
      q = x >>> 4;
      r = x - q * 16;
      case (m)
         2'd1: if (r >= 8) q++;
         2'd2: if (r > 8 || (r == 8 && q[0])) q++;
         default: ;
      endcase
      o = (q > 7) || (q < -8);
      y = q[3:0];
      if (o && s) y = (q > 7) ? 4'h7 : 4'h8;
      return {o, y};
   endfunction

   task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s, input logic [4:0] e);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.din      = d;
      bus.rnd_mode = m;
      bus.sat_en   = s;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: got in_ready=0 expected 1");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data", 32'({bus.ovf, bus.dout}), 32'({prev_ovf, prev_dout}));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_unexpected: got 0x%0h expected no output", {bus.ovf, bus.dout});
            end else begin
               exp5 = exp_q.pop_front();
               chk("sb_data", 32'({bus.ovf, bus.dout}), 32'(exp5));
               n_out++;
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_dout  = bus.dout;
         prev_ovf   = bus.ovf;
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.rnd_mode  = '0;
      bus.sat_en    = 1'b0;
      bus.out_ready = 1'b0;
      bus.cnt_clr   = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_ovf", 32'(bus.ovf), 0);
      chk("rst_dout", 32'(bus.dout), 0);
      chk("rst_ovf_cnt", 32'(bus.ovf_cnt), 0);
      rst_n = 1'b1;
      chk("rel_in_ready", 32'(bus.in_ready), 1);
      bus.out_ready = 1'b1;

      // Two-cycle latency from acceptance to out_valid.
      bus.in_valid = 1'b1; bus.din = 8'h08; bus.rnd_mode = RND_HALF_UP; bus.sat_en = 1'b0;
      exp_q.push_back(5'h01);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("lat_cycle1", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("lat_cycle2", 32'(bus.out_valid), 1);
      drain();

      send(8'h08, RND_HALF_EVEN, 1'b0, 5'h00);
      send(8'h08, RND_TRUNC,     1'b0, 5'h00);
      send(8'h18, RND_HALF_EVEN, 1'b0, 5'h02);
      send(8'h87, RND_TRUNC,     1'b0, 5'h08);
      send(8'hF8, RND_HALF_EVEN, 1'b0, 5'h00);
      send(8'h18, 2'd3,          1'b0, 5'h01);
      drain();
      chk("cnt_no_ovf", 32'(bus.ovf_cnt), 0);
      send(8'h7F, RND_HALF_UP, 1'b1, 5'h17);
      drain();
      chk("cnt_sat_ovf", 32'(bus.ovf_cnt), 1);
      send(8'h7F, RND_HALF_UP, 1'b0, 5'h18);
      drain();
      chk("cnt_wrap_ovf", 32'(bus.ovf_cnt), 2);

      // Back-to-back stream against a randomly stalling sink.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 128; i++) begin
               logic [7:0] v;
               logic [1:0] m;
               logic       s;
               v = 8'(i);
               m = 2'(i);
               s = 1'($urandom_range(0, 1));
               send(v, m, s, model(v, m, s));
            end
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
      chk("stream_count", n_out - n0, 128);

      // Fill both stages, then reset asynchronously mid-cycle.
      bus.out_ready = 1'b0;
      send(8'h10, RND_TRUNC, 1'b0, 5'h01);
      send(8'h20, RND_TRUNC, 1'b0, 5'h02);
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk("full_out_valid", 32'(bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_dout", 32'(bus.dout), 0);
      chk("arst_ovf_cnt", 32'(bus.ovf_cnt), 0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rel2_in_ready", 32'(bus.in_ready), 1);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.din = 8'h30; bus.rnd_mode = RND_TRUNC; bus.sat_en = 1'b0;
      exp_q.push_back(5'h03);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("post_rst_lat1", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("post_rst_lat2", 32'(bus.out_valid), 1);
      drain();

      // Saturate the overflow counter, then clear it against a live overflow.
      for (int i = 0; i < 65535; i++) send(8'h7F, RND_HALF_UP, 1'b1, 5'h17);
      drain();
      chk("cnt_full", 32'(bus.ovf_cnt), 32'hFFFF);
      send(8'h7F, RND_HALF_UP, 1'b1, 5'h17);
      drain();
      chk("cnt_stays_full", 32'(bus.ovf_cnt), 32'hFFFF);
      send(8'h7F, RND_HALF_UP, 1'b1, 5'h17);
      @(posedge clk); #1;
      chk("clr_out_valid", 32'(bus.out_valid), 1);
      chk("clr_ovf", 32'(bus.ovf), 1);
      bus.cnt_clr = 1'b1;
      @(posedge clk); #1;
      bus.cnt_clr = 1'b0;
      chk("clr_wins", 32'(bus.ovf_cnt), 0);
      chk("clr_sb_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("clr_holds", 32'(bus.ovf_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/requant.md
REQUANT -- requirements
Module: requant

Interface
REQ-001 N_BITS_IN, default 8, input word width, signed two's complement.
REQ-002 BIN_PT_IN, default 7, input fractional bits.
REQ-003 N_BITS_OUT, default 4, output word width, signed two's complement.
REQ-004 BIN_PT_OUT, default 3, output fractional bits; legal only with BIN_PT_OUT < BIN_PT_IN and (N_BITS_OUT-BIN_PT_OUT) <= (N_BITS_IN-BIN_PT_IN), i.e. narrowing only; elaboration SHALL fail otherwise.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  din qualifier.
REQ-008 in_ready  out  1  stage can accept din this cycle.
REQ-009 din  in  N_BITS_IN  input sample.
REQ-010 rnd_mode  in  2  0 truncate (floor), 1 round half up, 2 round half even, 3 treated as 0; sampled with each accepted din.
REQ-011 sat_en  in  1  1 saturate on overflow, 0 wrap; sampled with each accepted din.
REQ-012 out_valid  out  1  dout qualifier.
REQ-013 out_ready  in  1  downstream accepts dout.
REQ-014 dout  out  N_BITS_OUT  requantised sample.
REQ-015 ovf  out  1  registered with dout; 1 when that sample overflowed the output range.
REQ-016 ovf_cnt  out  16  count of accepted samples with ovf=1, saturating at 0xFFFF.
REQ-017 cnt_clr  in  1  synchronous clear of ovf_cnt.

Function
REQ-018 Two register stages: S1 rounding, S2 range check/saturation; latency from accepted din to out_valid SHALL be exactly 2 cycles with no stall.
REQ-019 Transfer on a port only when valid and ready both high at the clock edge; din/rnd_mode/sat_en SHALL be ignored when in_valid=0.
REQ-020 Each stage SHALL advance when it holds no data or the next stage advances in the same cycle; in_ready = S1 empty or S1 advancing (combinational from out_ready).
REQ-021 Full-throughput: with out_ready held 1, one sample per cycle SHALL be accepted and delivered, no bubbles.
REQ-022 While out_valid=1 and out_ready=0, dout, ovf and out_valid SHALL hold stable; no sample SHALL be lost or duplicated.
REQ-023 S1 drops D = BIN_PT_IN-BIN_PT_OUT LSBs; result width N_BITS_IN-D+1 (one guard bit) so rounding never wraps.
REQ-024 Truncate: floor (arithmetic shift). Half up: add 2^(D-1) then floor. Half even: add 2^(D-1)-1 plus the kept LSB, then floor.
REQ-025 S2 overflow = S1 result outside [-2^(N_BITS_OUT-1), 2^(N_BITS_OUT-1)-1]; sat_en=1 clamps to that limit, sat_en=0 keeps low N_BITS_OUT bits; ovf set in both cases.
REQ-026 ovf_cnt increments by 1 on each out handshake with ovf=1; cnt_clr wins over a simultaneous increment (result 0).
REQ-027 No combinational path from din to dout.

Reset
REQ-028 rst_n low SHALL immediately clear out_valid, ovf, ovf_cnt and both stage-valid flags; dout resets to 0.
REQ-029 Reset mid-operation discards all in-flight samples; in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-030 Data registers other than dout need no reset.

Structure
REQ-031 Shared package holds rnd_mode encodings (RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2) and OVF_CNT_W=16.
REQ-032 One sub-module, pipe_stage (parameterised width, valid/ready register slice), instantiated twice.

Verification (defaults 8/7 -> 4/3, D=4)
REQ-033 din=0x08, mode 1 -> dout=0x1; mode 2 -> 0x0; mode 0 -> 0x0; ovf=0 all.
REQ-034 din=0x18, mode 2 -> dout=0x2; din=0x87, mode 0 -> dout=0x8 (-1.0).
REQ-035 din=0x7F, mode 1, sat_en=1 -> dout=0x7, ovf=1, ovf_cnt 0->1; sat_en=0 -> dout=0x8, ovf=1.
REQ-036 Stream 0x00..0x7F back-to-back, out_ready random 50% -> all 128 outputs in order, matching model, stable while stalled.
REQ-037 Drive rst_n low with both stages full -> out_valid=0 asynchronously; after release first accepted sample appears exactly 2 cycles later.
REQ-038 Preload ovf_cnt to 0xFFFF via overflow stream -> stays 0xFFFF; cnt_clr with simultaneous overflow handshake -> 0.
